slc3_mem_ctrl: RTL and testbench

Parametrised, multi-cycle successor to the SLC-3 memory/IO subsystem. It accepts single-word read/write requests from the CPU datapath over a req/ready handshake and runs an explicit SRAM strobe sequence with configurable wait states. It decodes memory-mapped IO (switches, hex display, LEDs) and drives the active-low SRAM control pins and the tristate enable. It sits between the datapath/ISDU and the external 1Mx16 SRAM tristate buffer in the slc3 top level.

---
 rtl/slc3_mem_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_slc3_mem_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl: multi-cycle SRAM / memory-mapped IO controller for the SLC-3.
// Accepts one read/write request at a time over req/ready. SRAM accesses run
// SETUP -> ACCESS (WAIT_STATES cycles) -> DONE. The two IO addresses (switches/hex,
// LEDs) skip straight to DONE and never touch the SRAM pins.
module slc3_mem_ctrl #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned SRAM_ADDR_W = 20,
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned N_HEX       = 4,
   parameter int unsigned LED_W       = 12,
   parameter logic [ADDR_W-1:0] IO_HEX_ADDR = 16'hFFFF,
   parameter logic [ADDR_W-1:0] IO_LED_ADDR = 16'hFFFE
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   req,
   input  logic                   we,
   input  logic [1:0]             be,
   input  logic [ADDR_W-1:0]      addr,
   input  logic [DATA_W-1:0]      wdata,
   output logic [DATA_W-1:0]      rdata,
   output logic                   ready,
   output logic                   busy,
   input  logic [DATA_W-1:0]      Switches,
   output logic [4*N_HEX-1:0]     hex_out,
   output logic [LED_W-1:0]       LED,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0]      sram_wdata,
   input  logic [DATA_W-1:0]      sram_rdata,
   output logic                   sram_drive,
   output logic                   CE,
   output logic                   UB,
   output logic                   LB,
   output logic                   OE,
   output logic                   WE
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   we_q, we_d;
   logic [1:0]             be_q, be_d;
   logic                   io_q, io_d;
   logic                   iohex_q, iohex_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [SRAM_ADDR_W-1:0] saddr_q, saddr_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;
   logic [4*N_HEX-1:0]     hex_q, hex_d;
   logic [LED_W-1:0]       led_q, led_d;

   logic ce_q, ce_d;
   logic oe_q, oe_d;
   logic wen_q, wen_d;
   logic ub_q, ub_d;
   logic lb_q, lb_d;
   logic drive_q, drive_d;
   logic ready_q, ready_d;
   logic busy_q, busy_d;

   logic                   addr_is_io;
   logic [SRAM_ADDR_W-1:0] addr_ext;
   logic [DATA_W-1:0]      led_ext;
   logic [DATA_W-1:0]      io_rdata;
   logic                   io_read_done;

   // Address decode and zero-extension helpers
   always_comb begin
      addr_is_io = (addr == IO_HEX_ADDR) || (addr == IO_LED_ADDR);
      addr_ext = '0;
      addr_ext[ADDR_W-1:0] = addr;
      led_ext = '0;
      led_ext[LED_W-1:0] = led_q;
      io_rdata = iohex_q ? Switches : led_ext;
      io_read_done = (state_q == S_DONE) && io_q && !we_q;
   end

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state and datapath update logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      be_d    = be_q;
      io_d    = io_q;
      iohex_d = iohex_q;
      wdata_d = wdata_q;
      saddr_d = saddr_q;
      rdata_d = rdata_q;
      hex_d   = hex_q;
      led_d   = led_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d    = we;
               be_d    = (be == 2'b00) ? 2'b11 : be;
               wdata_d = wdata;
               io_d    = addr_is_io;
               iohex_d = (addr == IO_HEX_ADDR);
               if (addr_is_io) begin
                  state_d = S_DONE;
               end else begin
                  saddr_d = addr_ext;
                  state_d = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            cnt_d   = CNT_W'(WAIT_STATES - 1);
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (cnt_q == '0) begin
               if (!we_q) rdata_d = sram_rdata;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            if (io_q) begin
               if (we_q) begin
                  if (iohex_q) hex_d = wdata_q[4*N_HEX-1:0];
                  else         led_d = wdata_q[LED_W-1:0];
               end else begin
                  rdata_d = io_rdata;
               end
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are decoded from the next state and registered, so the pins
   // change on the same edge as the state and never glitch.
   always_comb begin
      ce_d    = 1'b1;
      oe_d    = 1'b1;
      wen_d   = 1'b1;
      ub_d    = 1'b1;
      lb_d    = 1'b1;
      drive_d = 1'b0;
      ready_d = (state_d == S_DONE);
      busy_d  = (state_d != S_IDLE);
      if ((state_d == S_SETUP) || (state_d == S_ACCESS)) begin
         ce_d = 1'b0;
         ub_d = ~be_d[1];
         lb_d = ~be_d[0];
         if (we_d) begin
            drive_d = 1'b1;
            if (state_d == S_ACCESS) wen_d = 1'b0;
         end else begin
            oe_d = 1'b0;
         end
      end
   end

   // Request latches, IO registers, read data and registered pin outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q   <= '0;
         we_q    <= 1'b0;
         be_q    <= 2'b11;
         io_q    <= 1'b0;
         iohex_q <= 1'b0;
         wdata_q <= '0;
         saddr_q <= '0;
         rdata_q <= '0;
         hex_q   <= '0;
         led_q   <= '0;
         ce_q    <= 1'b1;
         oe_q    <= 1'b1;
         wen_q   <= 1'b1;
         ub_q    <= 1'b1;
         lb_q    <= 1'b1;
         drive_q <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         be_q    <= be_d;
         io_q    <= io_d;
         iohex_q <= iohex_d;
         wdata_q <= wdata_d;
         saddr_q <= saddr_d;
         rdata_q <= rdata_d;
         hex_q   <= hex_d;
         led_q   <= led_d;
         ce_q    <= ce_d;
         oe_q    <= oe_d;
         wen_q   <= wen_d;
         ub_q    <= ub_d;
         lb_q    <= lb_d;
         drive_q <= drive_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   // Output mapping; IO reads expose Switches live during DONE, then hold the capture
   always_comb begin
      rdata      = io_read_done ? io_rdata : rdata_q;
      ready      = ready_q;
      busy       = busy_q;
      hex_out    = hex_q;
      LED        = led_q;
      sram_addr  = saddr_q;
      sram_wdata = wdata_q;
      sram_drive = drive_q;
      CE         = ce_q;
      UB         = ub_q;
      LB         = lb_q;
      OE         = oe_q;
      WE         = wen_q;
   end

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Scoreboard bench for slc3_mem_ctrl with a behavioural 16-bit SRAM model.
module tb_slc3_mem_ctrl;

   localparam int WS = 2;

   logic        Clk = 1'b0;
   logic        Reset, req, we;
   logic [1:0]  be;
   logic [15:0] addr, wdata, rdata, Switches, sram_wdata, sram_rdata, hex_out;
   logic        ready, busy, sram_drive, CE, UB, LB, OE, WE;
   logic [11:0] LED;
   logic [19:0] sram_addr;

   slc3_mem_ctrl #(
      .DATA_W(16), .ADDR_W(16), .SRAM_ADDR_W(20), .WAIT_STATES(WS),
      .N_HEX(4), .LED_W(12), .IO_HEX_ADDR(16'hFFFF), .IO_LED_ADDR(16'hFFFE)
   ) dut (
      .Clk(Clk), .Reset(Reset), .req(req), .we(we), .be(be), .addr(addr),
      .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
      .Switches(Switches), .hex_out(hex_out), .LED(LED),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .sram_drive(sram_drive), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // SRAM model driven purely from the controller pins
   logic [15:0] mem [0:1023];
   always @(posedge Clk) begin
      if (!CE && !WE) begin
         if (!UB) mem[sram_addr[9:0]][15:8] <= sram_wdata[15:8];
         if (!LB) mem[sram_addr[9:0]][7:0]  <= sram_wdata[7:0];
      end
   end
   assign sram_rdata = (!CE && !OE) ? mem[sram_addr[9:0]] : 16'h0000;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      bit          w;
      logic [15:0] exp;
      int          acc;
      int          lat;
   } exp_t;
   exp_t sb[$];

   logic [15:0] shadow [0:1023];
   logic [15:0] hex_sh;
   logic [11:0] led_sh;

   // Scoreboard: pop on every ready pulse, check latency and read data
   always @(negedge Clk) begin
      if (ready) begin
         if (sb.size() == 0) begin
            chk("spurious_ready", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            if (!e.w) chk("rdata", {16'h0, rdata}, {16'h0, e.exp});
         end
      end
   end

   // One transaction, starting just after a posedge with the DUT idle
   task automatic xfer(input bit w, input logic [1:0] b, input logic [15:0] a,
                       input logic [15:0] d, input bit poke);
      exp_t e;
      logic [1:0] be_eff, ub_lb_exp;
      logic [15:0] m;
      bit io, seen;
      int ce_n, oe_n, we_n, drv_n, busy_n, both_n, drvoe_n;
      ce_n = 0; oe_n = 0; we_n = 0; drv_n = 0; busy_n = 0; both_n = 0; drvoe_n = 0;
      seen = 0;
      io = (a == 16'hFFFF) || (a == 16'hFFFE);
      be_eff = (b == 2'b00) ? 2'b11 : b;
      ub_lb_exp = ~be_eff;
      e.w = w;
      e.lat = io ? 1 : WS + 2;
      e.exp = '0;
      if (!w) begin
         if (a == 16'hFFFF)      e.exp = Switches;
         else if (a == 16'hFFFE) e.exp = {4'h0, led_sh};
         else                    e.exp = shadow[a[9:0]];
      end else begin
         if (a == 16'hFFFF)      hex_sh = d;
         else if (a == 16'hFFFE) led_sh = d[11:0];
         else begin
            m = shadow[a[9:0]];
            if (be_eff[1]) m[15:8] = d[15:8];
            if (be_eff[0]) m[7:0]  = d[7:0];
            shadow[a[9:0]] = m;
         end
      end
      req = 1'b1; we = w; be = b; addr = a; wdata = d;
      @(posedge Clk); #1;
      e.acc = cyc;
      sb.push_back(e);
      req = 1'b0; we = 1'($urandom); be = 2'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge Clk);
         if (poke) req = (i == 1);
         if (!CE) begin
            ce_n++;
            chk("ub_lb", {30'h0, UB, LB}, {30'h0, ub_lb_exp});
            chk("sram_addr", {12'h0, sram_addr}, {16'h0, a});
         end
         if (!OE) oe_n++;
         if (!WE) we_n++;
         if (sram_drive) drv_n++;
         if (busy) busy_n++;
         if (!WE && !OE) both_n++;
         if (sram_drive && !OE) drvoe_n++;
         if (ready) seen = 1;
      end
      req = 1'b0;
      chk("ready_seen", {31'h0, seen}, 32'd1);
      @(posedge Clk); #1;
      chk("ce_cycles", ce_n, io ? 0 : WS + 1);
      chk("oe_cycles", oe_n, (io || w) ? 0 : WS + 1);
      chk("we_cycles", we_n, (!io && w) ? WS : 0);
      chk("drive_cycles", drv_n, (!io && w) ? WS + 1 : 0);
      chk("busy_cycles", busy_n, e.lat);
      chk("we_oe_overlap", both_n, 0);
      chk("drive_oe", drvoe_n, 0);
      if (!w) chk("rdata_hold", {16'h0, rdata}, {16'h0, e.exp});
      chk("hex_out", {16'h0, hex_out}, {16'h0, hex_sh});
      chk("led", {20'h0, LED}, {20'h0, led_sh});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] a, d;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = 16'h0000;
         shadow[i] = 16'h0000;
      end
      hex_sh = '0; led_sh = '0;
      Reset = 1'b1; req = 1'b0; we = 1'b0; be = 2'b11; addr = '0; wdata = '0;
      Switches = 16'h1234;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      chk("rst_strobes", {27'h0, CE, UB, LB, OE, WE}, 32'h1F);
      chk("rst_drive", {31'h0, sram_drive}, 32'd0);
      chk("rst_ready_busy", {30'h0, ready, busy}, 32'd0);
      chk("rst_hex", {16'h0, hex_out}, 32'd0);
      chk("rst_led", {20'h0, LED}, 32'd0);
      chk("rst_rdata", {16'h0, rdata}, 32'd0);
      chk("rst_sram_addr", {12'h0, sram_addr}, 32'd0);

      // SRAM write then read back, back-to-back
      xfer(1'b1, 2'b11, 16'h0040, 16'hBEEF, 1'b0);
      xfer(1'b0, 2'b11, 16'h0040, 16'h0000, 1'b0);

      // Memory-mapped IO
      xfer(1'b0, 2'b11, 16'hFFFF, 16'h0000, 1'b0);
      xfer(1'b1, 2'b11, 16'hFFFF, 16'hA5C3, 1'b0);
      xfer(1'b1, 2'b01, 16'hFFFE, 16'hFFFF, 1'b0);
      xfer(1'b0, 2'b11, 16'hFFFE, 16'h0000, 1'b0);

      // Byte enables
      xfer(1'b1, 2'b10, 16'h0041, 16'h1122, 1'b0);
      xfer(1'b0, 2'b11, 16'h0041, 16'h0000, 1'b0);
      xfer(1'b1, 2'b01, 16'h0041, 16'h5566, 1'b0);
      xfer(1'b0, 2'b00, 16'h0041, 16'h0000, 1'b0);
      xfer(1'b1, 2'b00, 16'h0042, 16'h3344, 1'b0);
      xfer(1'b0, 2'b11, 16'h0042, 16'h0000, 1'b0);

      // Reset during the first ACCESS cycle of a write
      req = 1'b1; we = 1'b1; be = 2'b11; addr = 16'h0100; wdata = 16'hDEAD;
      @(posedge Clk); #1 req = 1'b0;
      @(posedge Clk); #1;
      chk("abort_in_access", {30'h0, CE, WE}, 32'd0);
      Reset = 1'b1;
      @(posedge Clk); #1;
      chk("abort_strobes", {27'h0, CE, UB, LB, OE, WE}, 32'h1F);
      chk("abort_drive", {31'h0, sram_drive}, 32'd0);
      chk("abort_ready_busy", {30'h0, ready, busy}, 32'd0);
      chk("abort_hex", {16'h0, hex_out}, 32'd0);
      hex_sh = '0; led_sh = '0;
      Reset = 1'b0;
      @(posedge Clk); #1;
      chk("post_abort_idle", {30'h0, ready, busy}, 32'd0);
      xfer(1'b1, 2'b11, 16'h0100, 16'h7A7A, 1'b0);
      xfer(1'b0, 2'b11, 16'h0100, 16'h0000, 1'b1);
      xfer(1'b1, 2'b11, 16'hFFFE, 16'h0ABC, 1'b0);

      // Random SRAM traffic, requests poked while busy
      for (int i = 0; i < 6; i++) begin
         a = 16'h0200 + 16'($urandom_range(0, 255));
         d = 16'($urandom);
         xfer(1'b1, 2'($urandom), a, d, 1'($urandom));
         xfer(1'b0, 2'b11, a, 16'h0000, 1'b1);
      end

      repeat (3) @(posedge Clk);
      #1 chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
